// File: rtl/dibit_frame_serializer_pkg.sv
// Shared types and constants for the dibit frame serializer.
package dibit_frame_serializer_pkg;

    typedef logic [1:0] dibit_t;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        PAY,
        GAP
    } state_t;

    localparam dibit_t PREAMBLE   = 2'b11;
    localparam int     FRAME_BITS = 16;

endpackage

// File: rtl/dibit_frame_serializer_if.sv
// Source-side dibit push handshake: a word moves when din_valid && din_ready.
interface dibit_frame_serializer_if;
    import dibit_frame_serializer_pkg::*;

    dibit_t din;
    logic   din_valid;
    logic   din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/dibit_frame_serializer_dibit_fifo.sv
// Synchronous dibit FIFO with a registered read head and synchronous flush.
module dibit_fifo
    import dibit_frame_serializer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  dibit_t                   wr_data,
    input  logic                     pop,
    output dibit_t                   rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dibit_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    dibit_t          head_q, head_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // Forward a word written into the slot that becomes the head this cycle.
        head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign rd_data = head_q;
    assign count   = count_q;
    assign ready   = (count_q < CW'(DEPTH));

endmodule

// File: rtl/dibit_frame_serializer.sv
// Dibit-to-serial framer: "11" preamble, 16 payload bits, zero gap.
// Optional 16-bit frame counter output enabled by DIBIT_FRAME_SERIALIZER_FRAME_CNT_EN.
module dibit_frame_serializer
    import dibit_frame_serializer_pkg::*;
#(
    parameter int PAYLOAD_DIBITS = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_LEN        = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    dibit_frame_serializer_if.slave      in_if,
    output logic                         ser_out,
    output logic                         busy,
`ifdef DIBIT_FRAME_SERIALIZER_FRAME_CNT_EN
    output logic [15:0]                  frame_cnt,
`endif
    output logic                         frame_done
);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_MAX = (FRAME_BITS > GAP_LEN) ? FRAME_BITS : GAP_LEN;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dibit_t           shreg_q, shreg_d;
    logic             ser_q, ser_d;
    logic             fd_q, fd_d;
    logic             pop;
    logic             push;
    logic             full_frame;
    dibit_t           head;
    logic [CW-1:0]    fifo_count;

    assign push = in_if.din_valid && in_if.din_ready;

    dibit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (in_if.din),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .ready   (in_if.din_ready)
    );

    assign full_frame = (fifo_count >= CW'(PAYLOAD_DIBITS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ser_d   = 1'b0;
        fd_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_frame) begin
                    state_d = PRE;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                ser_d = PREAMBLE[cnt_q[0]];
                if (cnt_q == CNT_W'(1)) begin
                    state_d = PAY;
                    cnt_d   = '0;
                    pop     = 1'b1;
                    shreg_d = head;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PAY: begin
                ser_d = shreg_q[1];
                fd_d  = (cnt_q == CNT_W'(FRAME_BITS - 1));
                if (!cnt_q[0]) begin
                    shreg_d = {shreg_q[0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    pop     = 1'b1;
                    shreg_d = head;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                // The last gap cycle doubles as the idle launch check, so a
                // buffered frame follows after exactly GAP_LEN zero bits.
                if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = full_frame ? PRE : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ser_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ser_q   <= ser_d;
            fd_q    <= fd_d;
        end
    end

    assign ser_out    = ser_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != IDLE);

`ifdef DIBIT_FRAME_SERIALIZER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = fd_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dibit_frame_serializer.sv
// Scoreboarded bench for dibit_frame_serializer: a line receiver pops expected bits per payload bit.
module tb_dibit_frame_serializer;
    import dibit_frame_serializer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ser_out, busy, frame_done;
`ifdef DIBIT_FRAME_SERIALIZER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    dibit_frame_serializer_if bus ();

    dibit_frame_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus),
        .ser_out    (ser_out),
        .busy       (busy),
`ifdef DIBIT_FRAME_SERIALIZER_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int frames_seen = 0;
    int pre_cyc = 0;
    int prev_pre_cyc = 0;
    int mon_idx = -1;
    bit mon_prev = 1'b0;
    bit mon_armed = 1'b1;
    bit exp_q[$];

    // One clock: observe the line at the negedge, then drive the next input.
    task automatic tick(input bit v, input dibit_t d);
        bit eb;
        @(negedge clk);
        cyc++;
        if (reset) begin
            mon_idx = -1;
            mon_prev = 1'b0;
            mon_armed = 1'b1;
        end else if (mon_idx >= 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL payload_extra: got bit %0b, required no payload (queue empty)", ser_out);
            end else begin
                eb = exp_q.pop_front();
                if (ser_out !== eb) begin
                    errors++;
                    $display("FAIL payload_bit%0d: got %0b, required %0b", mon_idx, ser_out, eb);
                end
            end
            checks++;
            if (frame_done !== (mon_idx == 15)) begin
                errors++;
                $display("FAIL frame_done_bit%0d: got %0b, required %0b", mon_idx, frame_done, (mon_idx == 15));
            end
            if (mon_idx == 15) begin
                $display("frame %0d received at cycle %0d", frames_seen, cyc);
                mon_idx = -1;
                frames_seen++;
                mon_armed = 1'b0;
                mon_prev = 1'b0;
            end else begin
                mon_idx++;
            end
        end else begin
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL frame_done_stray: got %0b, required 0", frame_done);
            end
            if (ser_out === 1'b1 && mon_prev && mon_armed) begin
                mon_idx = 0;
                prev_pre_cyc = pre_cyc;
                pre_cyc = cyc;
            end else if (ser_out === 1'b0) begin
                mon_armed = 1'b1;
            end
            mon_prev = ser_out;
        end
        bus.din_valid = v;
        bus.din = d;
        if (v && bus.din_ready && !reset) begin
            exp_q.push_back(d[1]);
            exp_q.push_back(d[0]);
            acc_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.din_valid = 1'b0;
        bus.din = '0;
        repeat (3) tick(1'b0, 2'b00);
        reset = 1'b0;
        exp_q.delete();
        tick(1'b0, 2'b00);
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL reset_ser_out: got %0b, required 0", ser_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b, required 0", frame_done); end
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %0b, required 1", bus.din_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        dibit_t pat [8] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
        logic [21:0] seq = '0;
        logic [21:0] exp_seq = 22'b00_11_1100011011110001_00;
        int f0 = frames_seen;
        for (int i = 0; i < 8; i++) tick(1'b1, pat[i]);
        for (int i = 0; i < 22; i++) begin
            tick(1'b0, 2'b00);
            seq = {seq[20:0], ser_out};
        end
        checks++;
        if (seq !== exp_seq) begin errors++; $display("FAIL single_line_seq: got %b, required %b", seq, exp_seq); end
        checks++;
        if (frames_seen != f0 + 1) begin errors++; $display("FAIL single_frame_count: got %0d, required %0d", frames_seen - f0, 1); end
        $display("test_single_frame done");
    endtask

    task automatic test_partial();
        int bad = 0;
        int f0 = frames_seen;
        repeat (6) tick(1'b0, 2'b00);
        for (int i = 0; i < 7; i++) tick(1'b1, dibit_t'($urandom_range(3, 0)));
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 2'b00);
            if (ser_out !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL partial_idle: got %0d active cycles, required 0", bad); end
        tick(1'b1, dibit_t'($urandom_range(3, 0)));
        tick(1'b0, 2'b00);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy_push_cycle: got %0b, required 0", busy); end
        tick(1'b0, 2'b00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy_launch: got %0b, required 1", busy); end
        for (int k = 0; k < 40 && frames_seen < f0 + 1; k++) tick(1'b0, 2'b00);
        checks++;
        if (frames_seen != f0 + 1) begin errors++; $display("FAIL partial_frame_timeout: got %0d frames, required 1", frames_seen - f0); end
        $display("test_partial done");
    endtask

    task automatic test_back_to_back();
        int a0;
        int f0;
        bit seen8 = 1'b0;
        repeat (10) tick(1'b0, 2'b00);
        a0 = acc_cnt;
        f0 = frames_seen;
        for (int k = 0; k < 200 && acc_cnt < a0 + 16; k++) begin
            tick(1'b1, dibit_t'($urandom_range(3, 0)));
            if (acc_cnt == a0 + 8 && !seen8) begin
                seen8 = 1'b1;
                @(posedge clk);
                #1;
                checks++;
                if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %0b, required 0", bus.din_ready); end
            end
        end
        checks++;
        if (acc_cnt != a0 + 16) begin errors++; $display("FAIL b2b_push_timeout: got %0d accepted, required 16", acc_cnt - a0); end
        for (int k = 0; k < 100 && frames_seen < f0 + 2; k++) tick(1'b0, 2'b00);
        checks++;
        if (frames_seen != f0 + 2) begin errors++; $display("FAIL b2b_frame_timeout: got %0d frames, required 2", frames_seen - f0); end
        checks++;
        if (pre_cyc - prev_pre_cyc != 20) begin errors++; $display("FAIL b2b_preamble_spacing: got %0d, required 20", pre_cyc - prev_pre_cyc); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover_bits: got %0d, required 0", exp_q.size()); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_frame();
        dibit_t pat [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
        int f0;
        repeat (6) tick(1'b0, 2'b00);
        for (int i = 0; i < 8; i++) tick(1'b1, dibit_t'($urandom_range(3, 0)));
        for (int k = 0; k < 40 && mon_idx != 6; k++) tick(1'b0, 2'b00);
        checks++;
        if (mon_idx != 6) begin errors++; $display("FAIL midrst_reach_bit5: got idx %0d, required 6", mon_idx); end
        reset = 1'b1;
        tick(1'b0, 2'b00);
        exp_q.delete();
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL midrst_ser_out: got %0b, required 0", ser_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b, required 0", busy); end
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL midrst_din_ready: got %0b, required 1", bus.din_ready); end
        reset = 1'b0;
        tick(1'b0, 2'b00);
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %0b, required 1", bus.din_ready); end
        f0 = frames_seen;
        for (int i = 0; i < 8; i++) tick(1'b1, pat[i]);
        for (int k = 0; k < 40 && frames_seen < f0 + 1; k++) tick(1'b0, 2'b00);
        checks++;
        if (frames_seen != f0 + 1) begin errors++; $display("FAIL midrst_frame_timeout: got %0d frames, required 1", frames_seen - f0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_leftover_bits: got %0d, required 0", exp_q.size()); end
        $display("test_reset_mid_frame done");
    endtask

`ifdef DIBIT_FRAME_SERIALIZER_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int f0;
        reset = 1'b1;
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b00);
        reset = 1'b0;
        exp_q.delete();
        tick(1'b0, 2'b00);
        f0 = frames_seen;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) tick(1'b1, dibit_t'($urandom_range(3, 0)));
            tick(1'b0, 2'b00);
        end
        for (int k = 0; k < 120 && frames_seen < f0 + 3; k++) tick(1'b0, 2'b00);
        repeat (4) tick(1'b0, 2'b00);
        checks++;
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_cnt_three: got %0d, required 3", frame_cnt); end
        force dut.frame_cnt_q = 16'hFFFF;
        tick(1'b0, 2'b00);
        release dut.frame_cnt_q;
        f0 = frames_seen;
        for (int i = 0; i < 8; i++) tick(1'b1, dibit_t'($urandom_range(3, 0)));
        for (int k = 0; k < 40 && frames_seen < f0 + 1; k++) tick(1'b0, 2'b00);
        repeat (4) tick(1'b0, 2'b00);
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL frame_cnt_wrap: got %0d, required 0", frame_cnt); end
        $display("test_frame_cnt done");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_partial();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef DIBIT_FRAME_SERIALIZER_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
